// File: rtl/nv_ram_rwsthp_20x4_fifo_ctrl_pkg.sv
// Shared nv_ram FIFO controller constants.
// Depth/address/payload sizes reused by sibling nv_ram_rwsthp controllers.
package nv_ram_rwsthp_20x4_fifo_ctrl_pkg;

    localparam int FIFO_DEPTH_20X4 = 20;
    localparam int FIFO_AW         = 5;
    localparam int FIFO_DW         = 4;

endpackage

// File: rtl/nv_ram_rwsthp_20x4_fifo_ctrl_if.sv
// Valid/ready write and read channels of the 20x4 FIFO.
// slave: controller side; master: producer/consumer side.
interface nv_ram_rwsthp_20x4_fifo_ctrl_if;
    import nv_ram_rwsthp_20x4_fifo_ctrl_pkg::*;

    logic               wr_pvld;
    logic               wr_prdy;
    logic [FIFO_DW-1:0] wr_pd;
    logic               rd_pvld;
    logic               rd_prdy;
    logic [FIFO_DW-1:0] rd_pd;

    modport master (
        output wr_pvld,
        output wr_pd,
        input  wr_prdy,
        input  rd_pvld,
        input  rd_pd,
        output rd_prdy
    );

    modport slave (
        input  wr_pvld,
        input  wr_pd,
        output wr_prdy,
        output rd_pvld,
        output rd_pd,
        input  rd_prdy
    );

endinterface

// File: rtl/nv_ram_fifo_wrap_ptr.sv
// Mod-DEPTH pointer incrementer: ptr_nxt = ptr + 1, DEPTH-1 wraps to 0.
// Ports: ptr (current pointer), ptr_nxt (incremented pointer).
module nv_ram_fifo_wrap_ptr #(
    parameter int DEPTH = 20,
    parameter int AW    = 5
) (
    input  logic [AW-1:0] ptr,
    output logic [AW-1:0] ptr_nxt
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    assign ptr_nxt = (ptr == LAST) ? '0 : ptr + AW'(1);

endmodule

// File: rtl/nv_ram_rwsthp_20x4_fifo_ctrl.sv
// Valid/ready FIFO controller driving one nv_ram_rwsthp_20x4 as a 20x4 FIFO.
// Ports: clk, rst (sync, active-high), fifo (wr/rd handshakes),
// ram_* (RAM write/read/bypass controls), ram_dout (head), pwrbus_ram_pd.
module nv_ram_rwsthp_20x4_fifo_ctrl
    import nv_ram_rwsthp_20x4_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_20X4,
    parameter int AW    = FIFO_AW,
    parameter int DW    = FIFO_DW
) (
    input  logic          clk,
    input  logic          rst,
    nv_ram_rwsthp_20x4_fifo_ctrl_if.slave fifo,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    output logic          ram_byp_sel,
    output logic [DW-1:0] ram_dbyp,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd
);

    localparam int              OW       = AW + 1;
    localparam logic [OW-1:0]   OCC_FULL = OW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_inc;
    logic [AW-1:0] rd_ptr_inc;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_unread;
    logic          s1_vld;
    logic          s2_vld;

    logic          wr_prdy;
    logic          wr_fire;
    logic          s2_free;
    logic          byp;
    logic          pop;

    // The power bus goes straight to the RAM; nothing here uses it.
    logic          unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    nv_ram_fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
        .ptr     (wr_ptr),
        .ptr_nxt (wr_ptr_inc)
    );

    nv_ram_fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
        .ptr     (rd_ptr),
        .ptr_nxt (rd_ptr_inc)
    );

    // occ includes the slot held by stage 1; exclude it when deciding
    // whether another address may be launched.
    assign occ_unread = occ - {{AW{1'b0}}, s1_vld};

    assign wr_prdy = (occ != OCC_FULL);
    // Reset masks every RAM strobe even while state is still settling.
    assign wr_fire = fifo.wr_pvld & wr_prdy & !rst;
    assign s2_free = !s2_vld | fifo.rd_prdy;

    // Bypass only with nothing older in the RAM or stage 1.
    assign byp     = wr_fire & (occ == '0) & !s1_vld & s2_free;

    assign ram_we      = wr_fire & !byp;
    assign ram_wa      = wr_ptr;
    assign ram_di      = fifo.wr_pd;
    assign ram_ore     = (s1_vld & s2_free & !rst) | byp;
    assign ram_byp_sel = byp;
    assign ram_dbyp    = fifo.wr_pd;
    assign ram_re      = (occ_unread != '0) & (!s1_vld | ram_ore) & !rst;
    assign ram_ra      = rd_ptr;

    // A slot is freed at the ore edge, not at re.
    assign pop = ram_ore & !byp;

    assign fifo.wr_prdy = wr_prdy;
    assign fifo.rd_pvld = s2_vld & !rst;
    assign fifo.rd_pd   = ram_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (ram_we) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr_inc;
                s1_vld <= 1'b1;
            end else if (pop) begin
                s1_vld <= 1'b0;
            end
            occ    <= occ + {{AW{1'b0}}, ram_we} - {{AW{1'b0}}, pop};
            s2_vld <= ram_ore | (s2_vld & !fifo.rd_prdy);
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsthp_20x4_fifo_ctrl.sv
// Testbench for nv_ram_rwsthp_20x4_fifo_ctrl with a behavioural RAM.
// Directed vector table plus fill/drain/wrap/stream/reset sequences.
module tb_nv_ram_rwsthp_20x4_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ram_wa;
    logic        ram_we;
    logic [3:0]  ram_di;
    logic [4:0]  ram_ra;
    logic        ram_re;
    logic        ram_ore;
    logic        ram_byp_sel;
    logic [3:0]  ram_dbyp;
    logic [3:0]  ram_dout;
    logic [31:0] pwrbus_ram_pd = 32'h0;

    int checks = 0;
    int errors = 0;

    nv_ram_rwsthp_20x4_fifo_ctrl_if fif ();

    nv_ram_rwsthp_20x4_fifo_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .fifo          (fif),
        .ram_wa        (ram_wa),
        .ram_we        (ram_we),
        .ram_di        (ram_di),
        .ram_ra        (ram_ra),
        .ram_re        (ram_re),
        .ram_ore       (ram_ore),
        .ram_byp_sel   (ram_byp_sel),
        .ram_dbyp      (ram_dbyp),
        .ram_dout      (ram_dout),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    always #5 clk = ~clk;

    // Behavioural nv_ram_rwsthp_20x4: registered read address, output
    // register loaded on ore from the array or the bypass data.
    logic [3:0] mem [0:19];
    logic [4:0] ra_d;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
        if (ram_ore) ram_dout <= ram_byp_sel ? ram_dbyp : mem[ra_d];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       wv;
        logic [3:0] wd;
        logic       rr;
        logic       e_prdy;
        logic       e_pvld;
        logic [3:0] e_pd;
        logic       e_we;
        logic       e_re;
        logic       e_ore;
        logic       e_byp;
        logic [4:0] e_wa;
        logic [4:0] e_ra;
    } vec_t;

    vec_t       vt [11];
    logic [3:0] sb [$];
    logic [3:0] exp_pd;
    logic       prev_stall;
    logic [3:0] prev_pd;
    int         n;

    initial begin
        // rst wv wd rr | prdy pvld pd we re ore byp wa ra
        vt[0]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 4'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
        vt[1]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 4'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
        vt[2]  = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0,
                   1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0};
        vt[3]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA,
                   1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
        vt[4]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 4'hA,
                   1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
        vt[5]  = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 4'hA,
                   1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0};
        vt[6]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hA,
                   1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd1};
        vt[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h3,
                   1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0};
        vt[8]  = '{1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 4'h7,
                   1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0};
        vt[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h9,
                   1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
        vt[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};

        rst = 1'b1;
        fif.wr_pvld = 1'b1;
        fif.wr_pd = 4'h5;
        fif.rd_prdy = 1'b0;
        step();

        // Directed vectors: reset hold, bypass, RAM path, bypass again.
        for (int i = 0; i < 11; i++) begin
            rst = vt[i].rst;
            fif.wr_pvld = vt[i].wv;
            fif.wr_pd = vt[i].wd;
            fif.rd_prdy = vt[i].rr;
            @(negedge clk);
            chk($sformatf("v%0d_wr_prdy", i), 32'(fif.wr_prdy), 32'(vt[i].e_prdy));
            chk($sformatf("v%0d_rd_pvld", i), 32'(fif.rd_pvld), 32'(vt[i].e_pvld));
            chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(vt[i].e_we));
            chk($sformatf("v%0d_re", i), 32'(ram_re), 32'(vt[i].e_re));
            chk($sformatf("v%0d_ore", i), 32'(ram_ore), 32'(vt[i].e_ore));
            chk($sformatf("v%0d_byp", i), 32'(ram_byp_sel), 32'(vt[i].e_byp));
            if (vt[i].e_pvld)
                chk($sformatf("v%0d_rd_pd", i), 32'(fif.rd_pd), 32'(vt[i].e_pd));
            if (vt[i].e_we)
                chk($sformatf("v%0d_wa", i), 32'(ram_wa), 32'(vt[i].e_wa));
            if (vt[i].e_re)
                chk($sformatf("v%0d_ra", i), 32'(ram_ra), 32'(vt[i].e_ra));
            step();
        end

        // Fill under full back-pressure: 1 bypass + 20 RAM writes.
        rst = 1'b1;
        fif.wr_pvld = 1'b0;
        fif.rd_prdy = 1'b0;
        step();
        rst = 1'b0;
        sb.delete();
        for (int c = 0; c < 25; c++) begin
            fif.wr_pvld = 1'b1;
            fif.wr_pd = 4'(c % 5);
            fif.rd_prdy = 1'b0;
            @(negedge clk);
            chk($sformatf("fill%0d_prdy", c), 32'(fif.wr_prdy), 32'(c < 21));
            if (c == 0) begin
                chk("fill_first_byp", 32'(ram_byp_sel), 32'(1));
                chk("fill_first_we", 32'(ram_we), 32'(0));
            end else if (c <= 20) begin
                chk($sformatf("fill%0d_we", c), 32'(ram_we), 32'(1));
                chk($sformatf("fill%0d_wa", c), 32'(ram_wa), 32'(c - 1));
            end
            if (fif.wr_prdy) sb.push_back(fif.wr_pd);
            step();
        end

        // Drain from full; a write offered while full is still refused.
        n = 0;
        for (int c = 0; c < 60; c++) begin
            fif.wr_pvld = (c == 0);
            fif.wr_pd = 4'hF;
            fif.rd_prdy = 1'b1;
            @(negedge clk);
            if (c == 0)
                chk("full_rd_wr_prdy", 32'(fif.wr_prdy), 32'(0));
            if (fif.wr_pvld && fif.wr_prdy) sb.push_back(fif.wr_pd);
            if (fif.rd_pvld) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL drain_extra actual=%0h required=none", fif.rd_pd);
                end else begin
                    exp_pd = sb.pop_front();
                    chk($sformatf("drain%0d_pd", n), 32'(fif.rd_pd), 32'(exp_pd));
                end
                n++;
            end
            step();
        end
        chk("drain_count", 32'(n), 32'(21));

        // Wrap: pointer went 19 -> 0, so RAM writes land at 0,1,2.
        for (int c = 0; c < 4; c++) begin
            fif.wr_pvld = 1'b1;
            fif.wr_pd = 4'(4'hC + c);
            fif.rd_prdy = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                chk("wrap_byp", 32'(ram_byp_sel), 32'(1));
            end else begin
                chk($sformatf("wrap%0d_we", c), 32'(ram_we), 32'(1));
                chk($sformatf("wrap%0d_wa", c), 32'(ram_wa), 32'(c - 1));
            end
            if (fif.wr_prdy) sb.push_back(fif.wr_pd);
            step();
        end

        // Random streaming against the scoreboard.
        prev_stall = 1'b0;
        prev_pd = 4'h0;
        for (int c = 0; c < 2000; c++) begin
            fif.wr_pvld = 1'($urandom_range(0, 1));
            fif.wr_pd = 4'($urandom);
            fif.rd_prdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_pvld", 32'(fif.rd_pvld), 32'(1));
                chk("stall_pd", 32'(fif.rd_pd), 32'(prev_pd));
            end
            if (fif.wr_pvld && fif.wr_prdy) sb.push_back(fif.wr_pd);
            if (fif.rd_pvld && fif.rd_prdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra actual=%0h required=none", fif.rd_pd);
                end else begin
                    exp_pd = sb.pop_front();
                    chk("stream_pd", 32'(fif.rd_pd), 32'(exp_pd));
                end
            end
            chk("stream_cap", 32'(sb.size() <= 21), 32'(1));
            prev_stall = fif.rd_pvld & !fif.rd_prdy;
            prev_pd = fif.rd_pd;
            step();
        end

        // Drain what is left.
        for (int c = 0; c < 60; c++) begin
            fif.wr_pvld = 1'b0;
            fif.rd_prdy = 1'b1;
            @(negedge clk);
            if (fif.rd_pvld) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL final_extra actual=%0h required=none", fif.rd_pd);
                end else begin
                    exp_pd = sb.pop_front();
                    chk("final_pd", 32'(fif.rd_pd), 32'(exp_pd));
                end
            end
            step();
        end
        chk("final_left", 32'(sb.size()), 32'(0));

        // Mid-operation reset with occ=7 and stage 1 loaded.
        for (int c = 0; c < 8; c++) begin
            fif.wr_pvld = 1'b1;
            fif.wr_pd = 4'(c + 1);
            fif.rd_prdy = 1'b0;
            step();
        end
        rst = 1'b1;
        fif.wr_pvld = 1'b0;
        @(negedge clk);
        chk("mrst_we", 32'(ram_we), 32'(0));
        chk("mrst_re", 32'(ram_re), 32'(0));
        chk("mrst_ore", 32'(ram_ore), 32'(0));
        chk("mrst_pvld", 32'(fif.rd_pvld), 32'(0));
        step();
        rst = 1'b0;
        fif.wr_pvld = 1'b1;
        fif.wr_pd = 4'hB;
        fif.rd_prdy = 1'b1;
        @(negedge clk);
        chk("post_rst_pvld", 32'(fif.rd_pvld), 32'(0));
        chk("post_rst_prdy", 32'(fif.wr_prdy), 32'(1));
        chk("post_rst_byp", 32'(ram_byp_sel), 32'(1));
        chk("post_rst_we", 32'(ram_we), 32'(0));
        step();
        fif.wr_pvld = 1'b0;
        @(negedge clk);
        chk("post_rst_out_pvld", 32'(fif.rd_pvld), 32'(1));
        chk("post_rst_out_pd", 32'(fif.rd_pd), 32'(4'hB));
        step();
        @(negedge clk);
        chk("post_rst_empty", 32'(fif.rd_pvld), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
